operand_fetch: RTL and testbench

Operand-fetch stage between instruction fetch and execute. Accepts one 16-bit instruction per cycle and drives the register file's registered read addresses. One cycle later it presents the instruction fields with both source operands. Forwards the writeback value written in the same cycle, and interlocks on a 16-entry busy scoreboard so no instruction reads or overwrites a register whose write is still outstanding downstream.

---
 rtl/operand_fetch_if.sv | 37 +++
 rtl/operand_fetch.sv | 78 +++++++
 tb/tb_operand_fetch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Bundle between fetch, register file, writeback and execute for the operand-fetch stage.
// The stage itself connects through the slave modport.
interface operand_fetch_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic [3:0]  raddr0_;
    logic [3:0]  raddr1_;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        wb_wen;
    logic [3:0]  wb_waddr;
    logic [15:0] wb_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [3:0]  out_op;
    logic [3:0]  out_rt;
    logic [15:0] out_va;
    logic [15:0] out_vb;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, rdata0, rdata1,
               wb_wen, wb_waddr, wb_wdata, out_ready,
        output in_ready, raddr0_, raddr1_, out_valid, out_pc, out_op,
               out_rt, out_va, out_vb
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, rdata0, rdata1,
               wb_wen, wb_waddr, wb_wdata, out_ready,
        input  in_ready, raddr0_, raddr1_, out_valid, out_pc, out_op,
               out_rt, out_va, out_vb
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives regfile read addresses, holds one instruction with its operands,
// forwards same-cycle writebacks and interlocks on a per-register busy scoreboard.
module operand_fetch (
    input  logic             clk,
    input  logic             reset,
    operand_fetch_if.slave   bus
);
    logic        out_valid_q;
    logic [15:0] pc_q;
    logic [3:0]  op_q, rt_q, ra_q, rb_q;
    logic [15:0] busy_q;

    logic [3:0]  in_op, in_rt, in_ra, in_rb;
    logic        in_writes, held_writes;
    logic [15:0] wb_clear, busy_eff, busy_d;
    logic        slot_free, held_conflict, hazard, accept, fire;

    assign in_op = bus.in_instr[15:12];
    assign in_rt = bus.in_instr[11:8];
    assign in_ra = bus.in_instr[7:4];
    assign in_rb = bus.in_instr[3:0];

    // A register being released by this cycle's writeback is already free to use.
    always_comb begin
        in_writes     = (in_op[3:2] != 2'b11);
        held_writes   = (op_q[3:2] != 2'b11);
        wb_clear      = bus.wb_wen ? (16'd1 << bus.wb_waddr) : 16'd0;
        busy_eff      = busy_q & ~wb_clear;
        slot_free     = !out_valid_q || bus.out_ready;
        held_conflict = out_valid_q && held_writes &&
                        (rt_q == in_ra || rt_q == in_rb || rt_q == in_rt);
        hazard        = busy_eff[in_ra] || busy_eff[in_rb] ||
                        (in_writes && busy_eff[in_rt]) || held_conflict;
        accept        = bus.in_valid && !bus.flush && slot_free && !hazard;
        fire          = out_valid_q && bus.out_ready && !bus.flush;
        busy_d        = busy_eff;
        if (fire && held_writes) begin
            busy_d = busy_eff | (16'd1 << rt_q);
        end
    end

    assign bus.in_ready  = !bus.flush && slot_free && !hazard;
    assign bus.raddr0_   = slot_free ? in_ra : ra_q;
    assign bus.raddr1_   = slot_free ? in_rb : rb_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_op    = op_q;
    assign bus.out_rt    = rt_q;
    assign bus.out_va    = (bus.wb_wen && bus.wb_waddr == ra_q) ? bus.wb_wdata : bus.rdata0;
    assign bus.out_vb    = (bus.wb_wen && bus.wb_waddr == rb_q) ? bus.wb_wdata : bus.rdata1;

    // Flush drops the held slot but keeps busy bits of instructions already sent downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            op_q        <= '0;
            rt_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            busy_q      <= '0;
        end else begin
            busy_q <= busy_d;
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                pc_q        <= bus.in_pc;
                op_q        <= in_op;
                rt_q        <= in_rt;
                ra_q        <= in_ra;
                rb_q        <= in_rb;
            end else if (fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a write-through regfile model and a scoreboard of
// expected issued instructions compared whenever the stage fires.
module tb_operand_fetch;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    operand_fetch_if io();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (io.slave)
    );

    // Registered-read regfile; a write in the same cycle as the read is returned directly.
    logic [15:0] regs [16];
    always @(posedge clk) begin
        if (io.wb_wen) regs[io.wb_waddr] <= io.wb_wdata;
        io.rdata0 <= (io.wb_wen && io.wb_waddr == io.raddr0_) ? io.wb_wdata : regs[io.raddr0_];
        io.rdata1 <= (io.wb_wen && io.wb_waddr == io.raddr1_) ? io.wb_wdata : regs[io.raddr1_];
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  op;
        logic [3:0]  rt;
        logic [15:0] va;
        logic [15:0] vb;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                                 input logic ordy, input logic fl, input logic wen,
                                 input logic [3:0] wa, input logic [15:0] wd);
        io.in_valid  = v;
        io.in_instr  = instr;
        io.in_pc     = pc;
        io.out_ready = ordy;
        io.flush     = fl;
        io.wb_wen    = wen;
        io.wb_waddr  = wa;
        io.wb_wdata  = wd;
    endtask

    task automatic expectFire(input logic [15:0] pc, input logic [3:0] op, input logic [3:0] rt,
                              input logic [15:0] va, input logic [15:0] vb);
        exp_t e;
        e.pc = pc; e.op = op; e.rt = rt; e.va = va; e.vb = vb;
        sb_q.push_back(e);
    endtask

    // Compare the outgoing instruction whenever execute takes it, then advance one cycle.
    task automatic tick();
        exp_t e;
        #2;
        if (io.out_valid && io.out_ready && !io.flush) begin
            if (sb_q.size() == 0) begin
                checkOutput("fire_without_expectation", 16'(sb_q.size()), 16'd1);
            end else begin
                e = sb_q.pop_front();
                checkOutput("fire_pc", io.out_pc, e.pc);
                checkOutput("fire_op", 16'(io.out_op), 16'(e.op));
                checkOutput("fire_rt", 16'(io.out_rt), 16'(e.rt));
                checkOutput("fire_va", io.out_va, e.va);
                checkOutput("fire_vb", io.out_vb, e.vb);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        @(negedge clk);
        // Preload rN = 0xNNNN through the writeback port while the stage is held in reset.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 16'h0312, 16'h0000, 1'b0, 1'b0, 1'b1, i[3:0], {4{i[3:0]}});
            tick();
        end
        applyStimulus(1'b0, 16'h0312, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        checkOutput("reset_out_valid", 16'(io.out_valid), 16'd0);
        checkOutput("reset_out_pc", io.out_pc, 16'h0000);
        checkOutput("reset_out_op", 16'(io.out_op), 16'd0);
        checkOutput("reset_out_rt", 16'(io.out_rt), 16'd0);
        checkOutput("reset_raddr0", 16'(io.raddr0_), 16'd1);
        checkOutput("reset_raddr1", 16'(io.raddr1_), 16'd2);
        checkOutput("reset_in_ready", 16'(io.in_ready), 16'd1);
        reset = 1'b0;
        tick();

        // Back-to-back issue with no bubble.
        applyStimulus(1'b1, 16'h0312, 16'h0100, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("first_in_ready", 16'(io.in_ready), 16'd1);
        expectFire(16'h0100, 4'h0, 4'h3, 16'h1111, 16'h2222);
        tick();
        applyStimulus(1'b1, 16'h0412, 16'h0102, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        checkOutput("latency_out_valid", 16'(io.out_valid), 16'd1);
        checkOutput("no_bubble_in_ready", 16'(io.in_ready), 16'd1);
        expectFire(16'h0102, 4'h0, 4'h4, 16'h1111, 16'h2222);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h3, 16'h3333);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h4, 16'h4444);
        tick();

        // Writeback to a held source is forwarded in the same cycle.
        applyStimulus(1'b1, 16'h0312, 16'h0110, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        expectFire(16'h0110, 4'h0, 4'h3, 16'hBEEF, 16'h2222);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h1, 16'hBEEF);
        #1;
        checkOutput("fwd_out_va", io.out_va, 16'hBEEF);
        checkOutput("fwd_out_vb", io.out_vb, 16'h2222);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h3, 16'h3333);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h1, 16'h1111);
        tick();

        // RAW: reader of r5 waits for the r5 writeback.
        applyStimulus(1'b1, 16'h0512, 16'h0120, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        expectFire(16'h0120, 4'h0, 4'h5, 16'h1111, 16'h2222);
        tick();
        applyStimulus(1'b1, 16'h0655, 16'h0122, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("raw_held_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        #1 checkOutput("raw_busy_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        applyStimulus(1'b1, 16'h0655, 16'h0122, 1'b1, 1'b0, 1'b1, 4'h5, 16'h00A5);
        #1 checkOutput("raw_release_in_ready", 16'(io.in_ready), 16'd1);
        expectFire(16'h0122, 4'h0, 4'h6, 16'h00A5, 16'h00A5);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h6, 16'h6666);
        tick();

        // Store reading r5 stalls on the busy writer.
        applyStimulus(1'b1, 16'h0512, 16'h0130, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        expectFire(16'h0130, 4'h0, 4'h5, 16'h1111, 16'h2222);
        tick();
        applyStimulus(1'b1, 16'hC051, 16'h0132, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("store_held_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        #1 checkOutput("store_busy_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        applyStimulus(1'b1, 16'hC051, 16'h0132, 1'b1, 1'b0, 1'b1, 4'h5, 16'h0055);
        #1 checkOutput("store_release_in_ready", 16'(io.in_ready), 16'd1);
        expectFire(16'h0132, 4'hC, 4'h0, 16'h0055, 16'h1111);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();

        // WAW on r7.
        applyStimulus(1'b1, 16'h0712, 16'h0140, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        expectFire(16'h0140, 4'h0, 4'h7, 16'h1111, 16'h2222);
        tick();
        applyStimulus(1'b1, 16'h0734, 16'h0142, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("waw_held_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        #1 checkOutput("waw_busy_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        applyStimulus(1'b1, 16'h0734, 16'h0142, 1'b1, 1'b0, 1'b1, 4'h7, 16'h7070);
        #1 checkOutput("waw_release_in_ready", 16'(io.in_ready), 16'd1);
        expectFire(16'h0142, 4'h0, 4'h7, 16'h3333, 16'h4444);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h7, 16'h0707);
        tick();

        // Three-cycle downstream stall with a writeback to the held rb, then flush.
        applyStimulus(1'b1, 16'h0B12, 16'h0150, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        expectFire(16'h0150, 4'h0, 4'hB, 16'h1111, 16'h2222);
        tick();
        applyStimulus(1'b1, 16'h0912, 16'h0152, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("pre_stall_in_ready", 16'(io.in_ready), 16'd1);
        tick();
        applyStimulus(1'b1, 16'h0A34, 16'h0154, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        checkOutput("stall1_in_ready", 16'(io.in_ready), 16'd0);
        checkOutput("stall1_out_pc", io.out_pc, 16'h0152);
        checkOutput("stall1_out_rt", 16'(io.out_rt), 16'd9);
        checkOutput("stall1_out_vb", io.out_vb, 16'h2222);
        tick();
        applyStimulus(1'b1, 16'h0A34, 16'h0154, 1'b0, 1'b0, 1'b1, 4'h2, 16'h7777);
        #1;
        checkOutput("stall2_in_ready", 16'(io.in_ready), 16'd0);
        checkOutput("stall2_out_pc", io.out_pc, 16'h0152);
        checkOutput("stall2_out_vb", io.out_vb, 16'h7777);
        tick();
        applyStimulus(1'b1, 16'h0A34, 16'h0154, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        checkOutput("stall3_in_ready", 16'(io.in_ready), 16'd0);
        checkOutput("stall3_out_pc", io.out_pc, 16'h0152);
        checkOutput("stall3_out_va", io.out_va, 16'h1111);
        checkOutput("stall3_out_vb", io.out_vb, 16'h7777);
        tick();
        applyStimulus(1'b1, 16'h0A34, 16'h0154, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("flush_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        applyStimulus(1'b0, 16'h0A91, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        checkOutput("flush_out_valid", 16'(io.out_valid), 16'd0);
        checkOutput("flush_no_busy_set", 16'(io.in_ready), 16'd1);
        applyStimulus(1'b0, 16'h0AB1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("flush_keeps_busy", 16'(io.in_ready), 16'd0);
        tick();

        // Reset in the middle of a stall clears the slot and the scoreboard.
        applyStimulus(1'b1, 16'h0C12, 16'h0160, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("pre_reset_in_ready", 16'(io.in_ready), 16'd1);
        tick();
        applyStimulus(1'b1, 16'h0AB1, 16'h0162, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("pre_reset_stall", 16'(io.in_ready), 16'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("mid_reset_out_valid", 16'(io.out_valid), 16'd0);
        checkOutput("mid_reset_out_pc", io.out_pc, 16'h0000);
        checkOutput("mid_reset_in_ready", 16'(io.in_ready), 16'd1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();

        // A busy set on fire wins over a same-cycle clear of that register.
        applyStimulus(1'b1, 16'h0512, 16'h0170, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        expectFire(16'h0170, 4'h0, 4'h5, 16'h1111, 16'h7777);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h5, 16'h0555);
        tick();
        applyStimulus(1'b0, 16'h0655, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1 checkOutput("set_wins_in_ready", 16'(io.in_ready), 16'd0);
        tick();
        applyStimulus(1'b0, 16'h0655, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h5, 16'h0555);
        #1 checkOutput("wb_clear_in_ready", 16'(io.in_ready), 16'd1);
        tick();

        checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
